// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - state encoding, default widths and index helper for timer_sched
package timer_sched_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 8;

    // Requester count is capped at 8, so a fixed 8-bit one-hot encoder covers every build.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// rtl/timer_sched_rr_arbiter.sv - combinational round-robin winner search starting at ptr+1
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win
);

    int               idx;
    logic [N_REQ-1:0] oh;

    // Walk from the farthest candidate back to ptr+1 so the nearest set bit overwrites last.
    always_comb begin
        win = '0;
        idx = 0;
        oh  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            oh = N_REQ'(1) << idx;
            if (|(req & oh)) win = oh;
        end
    end

endmodule

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - round-robin shared timed-pulse engine; optional TIMER_SCHED_ABORT_EN aborts a run when its req drops
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] cyc_len,
    input  logic [N_REQ*CNT_W-1:0] up_len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    own;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] up_q;
    logic [N_REQ-1:0] win;
    logic [2:0]       win_idx3;
    logic [PW-1:0]    win_idx;
    logic [CNT_W-1:0] cyc_sel;
    logic [CNT_W-1:0] up_sel;
    logic             last;
    logic             abort;
    logic [CNT_W-1:0] cyc_arr [N_REQ];
    logic [CNT_W-1:0] up_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign cyc_arr[i] = cyc_len[i*CNT_W +: CNT_W];
        assign up_arr[i]  = up_len[i*CNT_W +: CNT_W];
    end

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    assign win_idx3 = onehot_idx(8'(win));
    assign win_idx  = win_idx3[PW-1:0];
    assign cyc_sel  = cyc_arr[win_idx];
    assign up_sel   = up_arr[win_idx];
    // cyc_q already holds max(cyc,1), so the run always ends before cnt could wrap.
    assign last     = (cnt == cyc_q - ONE);

`ifdef TIMER_SCHED_ABORT_EN
    assign abort = ~|(req & grant);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            o     <= 1'b0;
            cnt   <= '0;
            ptr   <= PW'(N_REQ - 1);
            own   <= '0;
            cyc_q <= '0;
            up_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= '0;
                    if (|req) begin
                        state <= ST_RUN;
                        grant <= win;
                        own   <= win_idx;
                        cyc_q <= (cyc_sel == '0) ? ONE : cyc_sel;
                        up_q  <= up_sel;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        o     <= (up_sel != '0);
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        o     <= 1'b0;
                        ptr   <= own;
                    end else if (last) begin
                        state <= ST_DONE;
                        done  <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        o     <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                        o   <= ((cnt + ONE) < up_q);
                    end
                end
                ST_DONE: begin
                    done  <= '0;
                    ptr   <= own;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    o     <= 1'b0;
                end
            endcase
        end
    end

endmodule
